uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Receives UART bytes on the FPGA pin and converts the serial line into the 8-bit valid/ready byte stream consumed by `alu`.
- Sits directly upstream of `alu`. `data_o`/`valid_o`/`ready_i` connect straight to the ALU's `data_i`/`valid_i`/`ready_o`.
- Frame format is fixed: 8N1, LSB first, idle-high line.
- A single-entry output holding register decouples the receiver from ALU back-pressure.

Parameters:
- ClksPerBit, 104, clock cycles per UART bit (12 MHz / 115200 ≈ 104). Must be ≥ 4.
- HalfBit, ClksPerBit/2 (integer divide), derived localparam; start-bit mid-sample offset. Not overridable.

Ports:
- clk_i  input  1  system clock; all logic on its posedge.
- rst_ni  input  1  reset, synchronous, active-low.
- rx_i  input  1  asynchronous serial line, idle high.
- data_o  output  8  received byte; stable while valid_o=1.
- valid_o  output  1  byte available in holding register.
- ready_i  input  1  downstream accepts byte when valid_o && ready_i at posedge.
- frame_err_o  output  1  one-cycle pulse: stop bit sampled 0.
- overrun_o  output  1  one-cycle pulse: completed byte dropped because holding register occupied.
- parity_err_o  output  1  one-cycle pulse: parity mismatch (see Optional Feature).

Behaviour:
- Clock and reset:
  - One clock domain.
  - Reset is synchronous, active-low, and applies on the posedge where rst_ni=0.
- Reset values:
  - data_o=0, valid_o=0, all error pulses=0.
  - State=IDLE; counters and shift register=0.
  - Synchronizer flops=1.
- Synchronizer: rx_i passes through a 2-flop synchronizer; `rx_s` is the second flop. A previous-value flop `rx_q` (reset 1) provides edge detection.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when the feature is enabled).
  - IDLE: when rx_q=1 and rx_s=0 (falling edge), go to START with cnt=0. A line held low never retriggers.
  - START: cnt increments each cycle. At cnt=HalfBit-1, sample rx_s.
    - rx_s=1: glitch; return to IDLE with no error.
    - rx_s=0: go to DATA with cnt=0, bit_idx=0.
  - DATA: at cnt=ClksPerBit-1, sample rx_s into shreg[bit_idx] (LSB first) and reset cnt. After bit_idx=7, go to STOP.
  - STOP: at cnt=ClksPerBit-1, sample rx_s.
    - 1: byte complete.
    - 0: pulse frame_err_o and discard the byte.
    - Either case: go to IDLE.
- Timing:
  - All samples land mid-bit: start at HalfBit, then each subsequent bit exactly ClksPerBit later.
  - Byte completion (stop-bit sample) occurs HalfBit + 9*ClksPerBit cycles after the first cycle rx_s=0.
- Holding register:
  - Completion with valid_o=0: on the next edge, data_o=shreg and valid_o=1.
  - Completion with valid_o=1, ready_i=0: byte dropped; data_o unchanged; overrun_o pulses 1 cycle.
  - Completion with valid_o=1, ready_i=1 in the same cycle: old byte consumed, new byte loaded; valid_o stays 1; no overrun.
  - No completion, valid_o && ready_i: valid_o clears next edge; data_o holds its last value.
- Receiver independence:
  - The receiver never stalls; back-pressure only affects the holding register.
  - A back-to-back frame (start bit immediately after stop) is received correctly: IDLE sees the falling edge because the stop bit left rx_q=1.
- Reset mid-frame: FSM aborts to IDLE and the holding register clears. Reception resumes on the next falling edge seen after reset release. A line already low at release is ignored until it returns high.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame becomes 8E1. A PARITY state between DATA and STOP samples one bit at ClksPerBit spacing.
  - Even parity check: ^shreg ^ parity_bit must be 0.
  - On mismatch: parity_err_o pulses 1 cycle at the stop sample and the byte is discarded, even if the stop bit is valid.
  - Frame error has priority; both pulses may assert in the same cycle.
  - Completion time becomes HalfBit + 10*ClksPerBit.
- Undefined: no PARITY state; parity_err_o tied 0; 8N1 as above.

Test Plan:
- All scenarios use ClksPerBit=4.
- Reset, then idle line (rx_i=1) for 50 cycles -> valid_o=0, data_o=0, no error pulses.
- Send 0xA5 with ready_i=1 -> valid_o high 1 cycle with data_o=0xA5, asserted 1 cycle after the stop sample (HalfBit+36 cycles after rx_s falls); repeat with 0x00, 0xFF, 231.
- Send 0x3C with ready_i=0, hold 20 cycles, then raise ready_i -> data_o=0x3C stable throughout; valid_o clears the cycle after the handshake.
- Send 0x11 then 0x22 back-to-back with ready_i=0 -> data_o=0x11 retained; overrun_o pulses once at 0x22's stop sample; 0x22 never appears.
- 1-cycle low glitch on rx_i -> returns to IDLE, no valid_o, no error. Frame 0x55 with stop bit driven 0 -> frame_err_o pulse, no valid_o. Next good frame 0x66 -> received correctly.
- Deassert rst_ni during DATA of 0x77, release, send 0x88 -> no output for 0x77; data_o=0x88, valid_o=1. With UART_RX_PARITY_EN, 0x01 with parity bit 0 -> parity_err_o pulse, no valid_o.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a single-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to receive 8E1 frames with an even-parity check.
module uart_rx #(
  parameter int unsigned ClksPerBit = 104
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       parity_err_o
);

  localparam int unsigned HalfBit = ClksPerBit / 2;
  localparam int unsigned CntW    = $clog2(ClksPerBit);
  localparam logic [CntW-1:0] CntHalf = CntW'(HalfBit - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(ClksPerBit - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  logic            rx_meta_q, rx_meta_d;
  logic            rx_s_q, rx_s_d;
  logic            rx_q, rx_d;
  logic [1:0]      sync_vld_q, sync_vld_d;
  logic            armed_q, armed_d;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            done;
  logic            par_bad;

`ifdef UART_RX_PARITY_EN
  logic            par_bad_q, par_bad_d;
  logic            parity_err_q, parity_err_d;
  assign par_bad      = par_bad_q;
  assign parity_err_o = parity_err_q;
`else
  assign par_bad      = 1'b0;
  assign parity_err_o = 1'b0;
`endif

  always_comb begin
    rx_meta_d   = rx_i;
    rx_s_d      = rx_meta_q;
    rx_d        = rx_s_q;
    sync_vld_d  = {sync_vld_q[0], 1'b1};
    // After reset the line must be seen high through a flushed synchronizer
    // before a falling edge may start a frame.
    armed_d     = armed_q | (sync_vld_q[1] & rx_s_q);
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    done        = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (armed_q && rx_q && !rx_s_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CntHalf) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CntLast) begin
          cnt_d              = '0;
          shreg_d[bit_idx_q] = rx_s_q;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CntLast) begin
          cnt_d     = '0;
          par_bad_d = (^shreg_q) ^ rx_s_q;
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`endif
      STOP: begin
        if (cnt_q == CntLast) begin
          cnt_d       = '0;
          state_d     = IDLE;
          frame_err_d = ~rx_s_q;
          done        = rx_s_q & ~par_bad;
`ifdef UART_RX_PARITY_EN
          parity_err_d = par_bad_q;
`endif
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A same-cycle handshake frees the slot for the byte completing now.
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    if (done) begin
      if (valid_q && !ready_i) begin
        overrun_d = 1'b1;
      end else begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_q        <= 1'b1;
      sync_vld_q  <= 2'b00;
      armed_q     <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shreg_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      rx_q        <= rx_d;
      sync_vld_q  <= sync_vld_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at ClksPerBit=4; honours UART_RX_PARITY_EN.
module tb_uart_rx;

  localparam int Cpb = 4;
`ifdef UART_RX_PARITY_EN
  localparam int FrameBits = 11;
`else
  localparam int FrameBits = 10;
`endif
  // rx_i falling edge to first valid_o cycle: 2 sync flops + HalfBit + (FrameBits-1)*Cpb + 1
  localparam int Lat = FrameBits * Cpb + 1;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       rx_i;
  logic       ready_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       parity_err_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_fall = 0;

  int n_valid = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  int n_perr = 0;
  int rise_cyc = 0;
  int ovr_cyc = 0;
  logic [7:0] rise_data = 8'h00;
  logic valid_prev = 1'b0;

  int bv, bf, bo, bp;
  logic stable;
  logic [7:0] vec [4];

`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  uart_rx #(.ClksPerBit(Cpb)) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .rx_i(rx_i),
    .data_o(data_o),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .frame_err_o(frame_err_o),
    .overrun_o(overrun_o),
    .parity_err_o(parity_err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    valid_prev <= valid_o;
    if (valid_o === 1'b1) n_valid <= n_valid + 1;
    if (valid_o === 1'b1 && valid_prev !== 1'b1) begin
      rise_cyc  <= cyc;
      rise_data <= data_o;
    end
    if (frame_err_o === 1'b1) n_ferr <= n_ferr + 1;
    if (overrun_o === 1'b1) begin
      n_ovr   <= n_ovr + 1;
      ovr_cyc <= cyc;
    end
    if (parity_err_o === 1'b1) n_perr <= n_perr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Caller is at a negedge; returns at the negedge ending the stop bit with the line high.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    t_fall = cyc;
    rx_i = 1'b0;
    repeat (Cpb) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (Cpb) @(negedge clk_i);
    end
`ifdef UART_RX_PARITY_EN
    rx_i = (^b) ^ par_flip;
    repeat (Cpb) @(negedge clk_i);
`endif
    rx_i = stop_bit;
    repeat (Cpb) @(negedge clk_i);
    rx_i = 1'b1;
  endtask

  initial begin
    vec[0] = 8'hA5; vec[1] = 8'h00; vec[2] = 8'hFF; vec[3] = 8'd231;
    rst_ni = 1'b0; rx_i = 1'b1; ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_data", 32'(data_o), 32'h00);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_ferr", 32'(frame_err_o), 32'h0);
    chk("rst_ovr", 32'(overrun_o), 32'h0);
    chk("rst_perr", 32'(parity_err_o), 32'h0);

    rst_ni = 1'b1;
    repeat (50) @(negedge clk_i);
    chk("idle_valid_cnt", 32'(n_valid), 32'd0);
    chk("idle_data", 32'(data_o), 32'h00);
    chk("idle_err_cnt", 32'(n_ferr + n_ovr + n_perr), 32'd0);

    ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bv = n_valid;
      send_byte(vec[k], 1'b1);
      repeat (6) @(negedge clk_i);
      chk("rx_valid_cycles", 32'(n_valid - bv), 32'd1);
      chk("rx_data", 32'(rise_data), 32'(vec[k]));
      chk("rx_latency", 32'(rise_cyc - t_fall), 32'(Lat));
    end

    ready_i = 1'b0;
    send_byte(8'h3C, 1'b1);
    repeat (3) @(negedge clk_i);
    chk("hold_valid", 32'(valid_o), 32'h1);
    chk("hold_data", 32'(data_o), 32'h3C);
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk_i);
      if (data_o !== 8'h3C || valid_o !== 1'b1) stable = 1'b0;
    end
    chk("hold_stable", 32'(stable), 32'h1);
    ready_i = 1'b1;
    @(negedge clk_i);
    chk("hold_valid_clear", 32'(valid_o), 32'h0);
    chk("hold_data_kept", 32'(data_o), 32'h3C);
    ready_i = 1'b0;
    repeat (4) @(negedge clk_i);

    bo = n_ovr;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    repeat (6) @(negedge clk_i);
    chk("ovr_data", 32'(data_o), 32'h11);
    chk("ovr_valid", 32'(valid_o), 32'h1);
    chk("ovr_count", 32'(n_ovr - bo), 32'd1);
    chk("ovr_timing", 32'(ovr_cyc - t_fall), 32'(Lat));
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    repeat (50) @(negedge clk_i);
    chk("ovr_drained", 32'(valid_o), 32'h0);
    chk("ovr_no_22", 32'(data_o), 32'h11);

    bv = n_valid; bf = n_ferr;
    rx_i = 1'b0;
    @(negedge clk_i);
    rx_i = 1'b1;
    repeat (20) @(negedge clk_i);
    chk("glitch_no_valid", 32'(n_valid - bv), 32'd0);
    chk("glitch_no_ferr", 32'(n_ferr - bf), 32'd0);

    send_byte(8'h55, 1'b0);
    repeat (6) @(negedge clk_i);
    chk("ferr_pulse", 32'(n_ferr - bf), 32'd1);
    chk("ferr_no_valid", 32'(n_valid - bv), 32'd0);

    ready_i = 1'b1;
    send_byte(8'h66, 1'b1);
    repeat (6) @(negedge clk_i);
    chk("after_ferr_valid", 32'(n_valid - bv), 32'd1);
    chk("after_ferr_data", 32'(rise_data), 32'h66);

    ready_i = 1'b0;
    bf = n_ferr; bo = n_ovr;
    fork
      send_byte(8'h77, 1'b1);
      begin
        repeat (20) @(negedge clk_i);
        rst_ni = 1'b0;
      end
    join
    repeat (3) @(negedge clk_i);
    chk("midrst_valid", 32'(valid_o), 32'h0);
    chk("midrst_data", 32'(data_o), 32'h00);
    rst_ni = 1'b1;
    repeat (10) @(negedge clk_i);
    send_byte(8'h88, 1'b1);
    repeat (6) @(negedge clk_i);
    chk("postrst_valid", 32'(valid_o), 32'h1);
    chk("postrst_data", 32'(data_o), 32'h88);
    chk("postrst_no_err", 32'((n_ferr - bf) + (n_ovr - bo)), 32'd0);

`ifdef UART_RX_PARITY_EN
    ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    bv = n_valid; bp = n_perr;
    par_flip = 1'b1;
    send_byte(8'h01, 1'b1);
    par_flip = 1'b0;
    repeat (6) @(negedge clk_i);
    chk("par_err_pulse", 32'(n_perr - bp), 32'd1);
    chk("par_no_valid", 32'(n_valid - bv), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
